// File: rtl/led_sweep_seq.sv
// led_sweep_seq
//   Drives the board LEDs from the tick-counter timebase strobe. Each rising
//   edge of i_valid, when i_enable is high, advances the pattern one step.
//   Four sweep modes are supported: rotate-left, rotate-right, ping-pong and
//   bar fill/clear. Every step is flagged on o_step. A step that completes a
//   pattern period is also flagged on o_wrap.
//
// Ports
//   clock     in   1        system clock, rising edge
//   i_reset   in   1        synchronous, active-high reset
//   i_valid   in   1        timebase strobe; only its rising edge matters
//   i_enable  in   1        1 = steps allowed, 0 = pattern frozen
//   i_mode    in   NB_MODE  00 rot-left, 01 rot-right, 10 ping-pong, 11 bar
//   o_led     out  NB_LEDS  registered LED pattern, bit0 = LED0
//   o_step    out  1        pulse in the cycle o_led takes a stepped value
//   o_wrap    out  1        pulse with the step that returns o_led to the seed
module led_sweep_seq #(
  parameter int NB_LEDS = 4,
  parameter int NB_MODE = 2
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic               i_enable,
  input  logic [NB_MODE-1:0] i_mode,
  output logic [NB_LEDS-1:0] o_led,
  output logic               o_step,
  output logic               o_wrap
);

  localparam logic [NB_MODE-1:0] MODE_ROTL = NB_MODE'(0);
  localparam logic [NB_MODE-1:0] MODE_ROTR = NB_MODE'(1);
  localparam logic [NB_MODE-1:0] MODE_PING = NB_MODE'(2);

  // Ping-pong direction and bar phase state encodings
  localparam logic [0:0] DIR_UP    = 1'b0;
  localparam logic [0:0] DIR_DOWN  = 1'b1;
  localparam logic [0:0] PH_FILL   = 1'b0;
  localparam logic [0:0] PH_CLEAR  = 1'b1;

  localparam logic [NB_LEDS-1:0] LED_LO   = {{(NB_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NB_LEDS-1:0] LED_HI   = {1'b1, {(NB_LEDS-1){1'b0}}};
  localparam logic [NB_LEDS-1:0] LED_ZERO = '0;
  localparam logic [NB_LEDS-1:0] LED_ONES = '1;

  function automatic logic [NB_LEDS-1:0] seed_of(input logic [NB_MODE-1:0] m);
    case (m)
      MODE_ROTL: seed_of = LED_LO;
      MODE_ROTR: seed_of = LED_HI;
      MODE_PING: seed_of = LED_LO;
      default:   seed_of = LED_ZERO;
    endcase
  endfunction

  logic               valid_d;
  logic [NB_MODE-1:0] mode_d;
  logic [0:0]         dir;
  logic [0:0]         phase;

  logic               step;
  logic               mode_chg;
  logic               is_onehot;
  logic               is_thermo;
  logic [NB_LEDS-1:0] inv_led;

  logic [NB_LEDS-1:0] nxt_led;
  logic [0:0]         nxt_dir;
  logic [0:0]         nxt_phase;
  logic               nxt_step;
  logic               nxt_wrap;

  assign step     = i_valid & ~valid_d & i_enable;
  assign mode_chg = (i_mode != mode_d);

  // x & (x-1) clears the lowest set bit; zero result with x!=0 means one-hot.
  assign is_onehot = (o_led != LED_ZERO) && ((o_led & (o_led - LED_LO)) == LED_ZERO);

  // A bar pattern is either ones packed at the bottom (filling) or ones
  // packed at the top (clearing). x & (x+1) is zero only for 0..01..1.
  assign inv_led   = ~o_led;
  assign is_thermo = ((o_led & (o_led + LED_LO)) == LED_ZERO) ||
                     ((inv_led & (inv_led + LED_LO)) == LED_ZERO);

  always_comb begin
    nxt_led   = o_led;
    nxt_dir   = dir;
    nxt_phase = phase;
    nxt_step  = 1'b0;
    nxt_wrap  = 1'b0;
    if (mode_chg) begin
      // Mode change wins over a coincident step; that step is dropped.
      nxt_led   = seed_of(i_mode);
      nxt_dir   = DIR_UP;
      nxt_phase = PH_FILL;
    end else if (step) begin
      nxt_step = 1'b1;
      case (mode_d)
        MODE_ROTL: begin
          if (!is_onehot) begin
            nxt_led = seed_of(mode_d);
          end else begin
            nxt_led  = {o_led[NB_LEDS-2:0], o_led[NB_LEDS-1]};
            nxt_wrap = (nxt_led == LED_LO);
          end
        end
        MODE_ROTR: begin
          if (!is_onehot) begin
            nxt_led = seed_of(mode_d);
          end else begin
            nxt_led  = {o_led[0], o_led[NB_LEDS-1:1]};
            nxt_wrap = (nxt_led == LED_HI);
          end
        end
        MODE_PING: begin
          if (!is_onehot) begin
            nxt_led = seed_of(mode_d);
            nxt_dir = DIR_UP;
          end else if (dir == DIR_UP) begin
            nxt_led = {o_led[NB_LEDS-2:0], 1'b0};
            // Turn as soon as the top LED lights so it is shown only once.
            if (nxt_led[NB_LEDS-1]) nxt_dir = DIR_DOWN;
          end else begin
            nxt_led = {1'b0, o_led[NB_LEDS-1:1]};
            if (nxt_led[0]) begin
              nxt_dir  = DIR_UP;
              nxt_wrap = 1'b1;
            end
          end
        end
        default: begin
          if (!is_thermo) begin
            nxt_led   = seed_of(mode_d);
            nxt_phase = PH_FILL;
          end else if (phase == PH_FILL) begin
            nxt_led = {o_led[NB_LEDS-2:0], 1'b1};
            if (nxt_led == LED_ONES) nxt_phase = PH_CLEAR;
          end else begin
            nxt_led = {o_led[NB_LEDS-2:0], 1'b0};
            if (nxt_led == LED_ZERO) begin
              nxt_phase = PH_FILL;
              nxt_wrap  = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      o_led   <= seed_of(i_mode);
      o_step  <= 1'b0;
      o_wrap  <= 1'b0;
      valid_d <= 1'b0;
      mode_d  <= i_mode;
      dir     <= DIR_UP;
      phase   <= PH_FILL;
    end else begin
      o_led   <= nxt_led;
      o_step  <= nxt_step;
      o_wrap  <= nxt_wrap;
      valid_d <= i_valid;
      mode_d  <= i_mode;
      dir     <= nxt_dir;
      phase   <= nxt_phase;
    end
  end

endmodule

// File: tb/tb_led_sweep_seq.sv
// tb_led_sweep_seq
//   Bench for led_sweep_seq with NB_LEDS=4. The reference model tracks only
//   the mode and a position index within the mode's period. The expected LED
//   pattern is computed arithmetically from that index. Expected steps are
//   queued and a monitor on the opposite clock edge pops and compares them
//   whenever the DUT flags a step.
module tb_led_sweep_seq;
  localparam int N = 4;

  logic         clock = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_enable = 1'b1;
  logic [1:0]   i_mode = 2'b00;
  logic [N-1:0] o_led;
  logic         o_step;
  logic         o_wrap;

  int errors = 0;
  int checks = 0;
  int steps_seen = 0;

  led_sweep_seq #(.NB_LEDS(N), .NB_MODE(2)) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .i_enable(i_enable),
    .i_mode  (i_mode),
    .o_led   (o_led),
    .o_step  (o_step),
    .o_wrap  (o_wrap)
  );

  always #5 clock = ~clock;

  function automatic int period(input logic [1:0] m);
    case (m)
      2'd0, 2'd1: return N;
      2'd2:       return 2*N - 2;
      default:    return 2*N;
    endcase
  endfunction

  // k-th pattern of a mode's period, with k=0 being the seed
  function automatic logic [N-1:0] pat(input logic [1:0] m, input int k);
    logic [N-1:0] one;
    logic [N-1:0] ones;
    logic [63:0]  fill;
    int p;
    one  = 1;
    ones = '1;
    case (m)
      2'd0: return one << k;
      2'd1: return (one << (N-1)) >> k;
      2'd2: begin
        p = (k < N) ? k : (2*N - 2 - k);
        return one << p;
      end
      default: begin
        if (k <= N) begin
          fill = (64'd1 << k) - 64'd1;
          return fill[N-1:0];
        end
        return ones << (k - N);
      end
    endcase
  endfunction

  // Reference model state
  logic [1:0]   m_mode = 2'b00;
  logic         m_vd = 1'b0;
  int           m_idx = 0;
  logic [N:0]   exp_q[$];   // {wrap, led}

  always @(posedge clock) begin
    int nidx;
    if (i_reset) begin
      m_mode <= i_mode;
      m_vd   <= 1'b0;
      m_idx  <= 0;
    end else begin
      m_vd <= i_valid;
      if (i_mode != m_mode) begin
        m_mode <= i_mode;
        m_idx  <= 0;
      end else if (i_valid && !m_vd && i_enable) begin
        nidx = (m_idx + 1) % period(m_mode);
        m_idx <= nidx;
        exp_q.push_back({(nidx == 0), pat(m_mode, nidx)});
      end
    end
  end

  // Monitor
  always @(negedge clock) begin
    logic [N:0] e;
    checks++;
    if (o_led !== pat(m_mode, m_idx)) begin
      errors++;
      $display("FAIL led_state t=%0t got=%b want=%b", $time, o_led, pat(m_mode, m_idx));
    end
    checks++;
    if (o_wrap && !o_step) begin
      errors++;
      $display("FAIL wrap_without_step t=%0t got wrap=%b step=%b want step=1", $time, o_wrap, o_step);
    end
    if (o_step === 1'b1 || exp_q.size() != 0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_step t=%0t got step=%b led=%b want no step", $time, o_step, o_led);
      end else begin
        e = exp_q.pop_front();
        if (o_step !== 1'b1 || o_led !== e[N-1:0] || o_wrap !== e[N]) begin
          errors++;
          $display("FAIL step t=%0t got step=%b led=%b wrap=%b want step=1 led=%b wrap=%b",
                   $time, o_step, o_led, o_wrap, e[N-1:0], e[N]);
        end
      end
    end
    if (o_step === 1'b1) steps_seen++;
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic strobe(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock) i_valid = 1'b1;
      @(negedge clock) i_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input logic [1:0] m);
    @(negedge clock);
    i_mode  = m;
    i_reset = 1'b1;
    @(negedge clock);
    i_reset = 1'b0;
  endtask

  initial begin
    // 1: rot-left period
    do_reset(2'b00);
    cyc(2);
    strobe(4);
    // 2: rot-right, long strobe gives one step
    do_reset(2'b01);
    @(negedge clock) i_valid = 1'b1;
    cyc(10);
    i_valid = 1'b0;
    cyc(2);
    // 3: ping-pong
    do_reset(2'b10);
    strobe(7);
    // 4: bar
    do_reset(2'b11);
    strobe(9);
    // 5: disabled strobes are lost
    i_enable = 1'b0;
    strobe(3);
    i_enable = 1'b1;
    cyc(2);
    strobe(1);
    // 6a: mode change coincident with a strobe edge
    do_reset(2'b00);
    strobe(2);
    @(negedge clock);
    i_mode  = 2'b10;
    i_valid = 1'b1;
    @(negedge clock) i_valid = 1'b0;
    cyc(2);
    strobe(2);
    // 6b: reset mid-CLEAR, then bar restarts in FILL
    do_reset(2'b11);
    strobe(5);
    do_reset(2'b11);
    strobe(2);
    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      i_valid  = ($urandom_range(0, 2) == 0);
      i_enable = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 59) == 0) i_mode = 2'($urandom_range(0, 3));
      i_reset  = ($urandom_range(0, 299) == 0);
    end
    i_reset = 1'b0;
    i_valid = 1'b0;
    cyc(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d pending want=0", exp_q.size());
    end
    checks++;
    if (steps_seen < 50) begin
      errors++;
      $display("FAIL step_activity got=%0d steps want>=50", steps_seen);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
